// File: rtl/fetch_unit_pkg.sv
// Shared defaults and state encoding for the instruction fetch unit.
package fetch_unit_pkg;

  localparam int FETCH_INSTR_BYTES = 2;
  localparam int FETCH_QUEUE_DEPTH = 2;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_REQ,
    FETCH_WAIT,
    FETCH_STALL
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_queue.sv
// Prefetch queue: synchronous FIFO with flush (flush beats push), head visible combinationally.
// Callers never push into a full queue unless popping in the same cycle.
module fetch_queue #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: byte reads assembled MSB-first into words, buffered in a prefetch queue.
// One outstanding read; jump flushes the queue and discards a read already in flight.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_BITS   = 8,
  parameter int DATA_BITS   = 8,
  parameter int INSTR_BYTES = FETCH_INSTR_BYTES,
  parameter int QUEUE_DEPTH = FETCH_QUEUE_DEPTH
) (
  input  logic                             clk,
  input  logic                             reset,
  output logic                             mem_rd_en,
  output logic [ADDR_BITS-1:0]             mem_addr,
  input  logic [DATA_BITS-1:0]             mem_rdata,
  input  logic                             mem_rvalid,
  input  logic                             jump_en,
  input  logic [ADDR_BITS-1:0]             jump_target,
  output logic                             instr_valid,
  input  logic                             instr_ready,
  output logic [INSTR_BYTES*DATA_BITS-1:0] instr_data,
  output logic [ADDR_BITS-1:0]             instr_pc
);

  localparam int CNT_W  = $clog2(QUEUE_DEPTH + 1);
  localparam int BCNT_W = (INSTR_BYTES > 1) ? $clog2(INSTR_BYTES) : 1;

  typedef struct packed {
    logic [0:INSTR_BYTES-1][DATA_BITS-1:0] word;
    logic [ADDR_BITS-1:0]                  pc;
  } entry_t;

  fetch_state_t state, state_nxt;
  logic [ADDR_BITS-1:0] fetch_pc;
  logic [ADDR_BITS-1:0] start_pc;
  logic [BCNT_W-1:0]    byte_cnt;
  logic                 discard;
  logic [0:INSTR_BYTES-1][DATA_BITS-1:0] asm_q;
  logic [0:INSTR_BYTES-1][DATA_BITS-1:0] asm_nxt;

  logic [CNT_W-1:0] q_count;
  logic [CNT_W:0]   cnt_after_push;
  entry_t           push_entry;
  entry_t           head_entry;
  logic q_pop, q_push, q_space, room_after_push;
  logic resp, take, last_byte, issue, in_flight_on_jump;

  assign q_pop     = instr_valid && instr_ready;
  assign q_space   = (q_count < CNT_W'(QUEUE_DEPTH)) || q_pop;
  assign resp      = (state == FETCH_WAIT) && mem_rvalid;
  assign take      = resp && !discard;
  assign last_byte = (byte_cnt == BCNT_W'(INSTR_BYTES - 1));
  assign q_push    = take && last_byte && !jump_en;
  // A new instruction only starts when its result is guaranteed a queue slot.
  assign issue     = (state == FETCH_REQ) && !jump_en &&
                     ((byte_cnt != '0) || q_space);

  assign cnt_after_push  = {1'b0, q_count} + (CNT_W+1)'(1) - (CNT_W+1)'(q_pop);
  assign room_after_push = cnt_after_push < (CNT_W+1)'(QUEUE_DEPTH);
  // A jump in WAIT leaves a response owed unless it is arriving right now.
  assign in_flight_on_jump = (state == FETCH_WAIT) && !mem_rvalid;

  always_comb begin
    asm_nxt           = asm_q;
    asm_nxt[byte_cnt] = mem_rdata;
  end

  always_comb begin
    push_entry      = '0;
    push_entry.word = asm_nxt;
    push_entry.pc   = start_pc;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH_IDLE:  state_nxt = FETCH_REQ;
      FETCH_REQ: begin
        if (issue) state_nxt = FETCH_WAIT;
        else if (!q_space) state_nxt = FETCH_STALL;
      end
      FETCH_WAIT: begin
        if (resp) begin
          if (discard) state_nxt = FETCH_REQ;
          else if (!last_byte) state_nxt = FETCH_REQ;
          else state_nxt = room_after_push ? FETCH_REQ : FETCH_STALL;
        end
      end
      FETCH_STALL: if (q_space) state_nxt = FETCH_REQ;
      default:     state_nxt = FETCH_IDLE;
    endcase
    if (jump_en) state_nxt = in_flight_on_jump ? FETCH_WAIT : FETCH_REQ;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= FETCH_IDLE;
      fetch_pc <= '0;
      start_pc <= '0;
      byte_cnt <= '0;
      discard  <= 1'b0;
      asm_q    <= '0;
    end else begin
      state <= state_nxt;
      if (jump_en) begin
        fetch_pc <= jump_target;
        byte_cnt <= '0;
        discard  <= in_flight_on_jump;
      end else begin
        if (issue) fetch_pc <= fetch_pc + ADDR_BITS'(1);
        if (issue && (byte_cnt == '0)) start_pc <= fetch_pc;
        if (take) begin
          asm_q[byte_cnt] <= mem_rdata;
          byte_cnt        <= last_byte ? '0 : byte_cnt + BCNT_W'(1);
        end
        if (resp && discard) discard <= 1'b0;
      end
    end
  end

  fetch_queue #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (q_push),
    .push_data (push_entry),
    .pop       (q_pop),
    .flush     (jump_en),
    .head_data (head_entry),
    .count     (q_count)
  );

  assign mem_rd_en   = issue;
  assign mem_addr    = fetch_pc;
  assign instr_valid = (q_count != '0);
  assign instr_data  = instr_valid ? head_entry.word : '0;
  assign instr_pc    = instr_valid ? head_entry.pc : '0;

endmodule
